// File: rtl/alu_ea_sequencer.sv
// Effective-address sequencer: time-shares the 8-bit ALU adder to form 16-bit
// indexed and relative-branch addresses in a low pass plus an optional high fix-up pass.
module alu_ea_sequencer #(
  parameter bit         ALWAYS_HI_PASS  = 1'b0,
  parameter logic [1:0] IDLE_CARRY_CODE = 2'b11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_base,
  input  logic [7:0]  i_offset,
  input  logic        i_offset_signed,
  input  logic [7:0]  i_alu_sum,
  input  logic        i_alu_cout,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [1:0]  o_carry_mux_code,
  output logic        o_alu_own,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_ea,
  output logic        o_page_cross
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_base;
  logic [7:0]  r_offset;
  logic        r_signed;
  logic        r_clo;
  logic [15:0] r_ea;
  logic        r_pc;
  logic        w_pc;
  logic        w_neg;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic [1:0]  w_code;
  logic        w_own;
  logic        w_busy;
  logic        w_done;

  // A negative displacement crosses a page when the low add does NOT carry.
  assign w_neg = r_signed & r_offset[7];
  assign w_pc  = w_neg ? ~i_alu_cout : i_alu_cout;

  always_comb begin
    w_next  = S_IDLE;
    w_alu_a = 8'h00;
    w_alu_b = 8'h00;
    w_code  = IDLE_CARRY_CODE;
    w_own   = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = i_start ? S_LO : S_IDLE;
      end
      S_LO: begin
        w_own   = 1'b1;
        w_busy  = 1'b1;
        w_alu_a = r_base[7:0];
        w_alu_b = r_offset;
        w_code  = 2'b01;
        w_next  = (w_pc || ALWAYS_HI_PASS) ? S_HI : S_DONE;
      end
      S_HI: begin
        w_own   = 1'b1;
        w_busy  = 1'b1;
        w_alu_a = r_base[15:8];
        w_alu_b = w_neg ? 8'hFF : 8'h00;
        w_code  = r_clo ? 2'b10 : 2'b01;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_base   <= 16'h0000;
      r_offset <= 8'h00;
      r_signed <= 1'b0;
      r_clo    <= 1'b0;
      r_ea     <= 16'h0000;
      r_pc     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base   <= i_base;
            r_offset <= i_offset;
            r_signed <= i_offset_signed;
          end
        end
        S_LO: begin
          r_ea[7:0] <= i_alu_sum;
          r_clo     <= i_alu_cout;
          r_pc      <= w_pc;
          if (!(w_pc || ALWAYS_HI_PASS))
            r_ea[15:8] <= r_base[15:8];
        end
        S_HI: r_ea[15:8] <= i_alu_sum;
        default: ;
      endcase
    end
  end

  assign o_alu_a          = w_alu_a;
  assign o_alu_b          = w_alu_b;
  assign o_carry_mux_code = w_code;
  assign o_alu_own        = w_own;
  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_ea             = r_ea;
  assign o_page_cross     = r_pc;

endmodule
